// File: rtl/counter.sv
// Synchronous up/down counter with zero/all-ones flags and a cascadable terminal-count strobe.
// Define COUNTER_SATURATE_EN to make the count saturate at the ends instead of wrapping.
module counter #(
    parameter int              WIDTH = 4,
    parameter logic [WIDTH-1:0] INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dn,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             ones,
    output logic             tc
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             step;

    // Flags decode only the register; tc adds the live en/dn so a downstream stage can use it as its enable.
    assign zero  = (count_reg == '0);
    assign ones  = &count_reg;
    assign tc    = en & ((~dn & ones) | (dn & zero));
    assign count = count_reg;

`ifdef COUNTER_SATURATE_EN
    // At an end point the step that would wrap is exactly the tc condition, so suppress it.
    assign step = en & ~tc;
`else
    assign step = en;
`endif

    always_comb begin
        count_next = count_reg;
        if (step) begin
            if (dn) begin
                count_next = count_reg - 1'b1;
            end else begin
                count_next = count_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= INIT;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: tb/tb_counter.sv
// Directed self-checking bench for the 4-bit counter; the saturation section runs when COUNTER_SATURATE_EN is defined.
module tb_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       dn;
    logic [3:0] count;
    logic       zero;
    logic       ones;
    logic       tc;

    int total_cnt;
    int bad_cnt;

    counter #(.WIDTH(4), .INIT(4'd0)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .dn    (dn),
        .count (count),
        .zero  (zero),
        .ones  (ones),
        .tc    (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s: got=%0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int up_seq[4]   = '{1, 2, 3, 4};
    int down_seq[5] = '{3, 2, 1, 0, 15};
    int rst_seq[3]  = '{15, 14, 13};
    int wrap_seq[4] = '{14, 15, 0, 1};

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst = 1'b1;
        en  = 1'b0;
        dn  = 1'b0;

        // Reset for two edges with en low
        tick();
        tick();
        chk("rst_count", 32'(count), 0);
        chk("rst_zero", 32'(zero), 1);
        chk("rst_ones", 32'(ones), 0);
        chk("rst_tc", 32'(tc), 0);
        rst = 1'b0;
        tick();
        chk("hold_after_rst", 32'(count), 0);

        // Count up 0 -> 4
        en = 1'b1;
        dn = 1'b0;
        #1;
        chk("tc_up_at0", 32'(tc), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("up_%0d", i), 32'(count), 32'(up_seq[i]));
        end
        chk("zero_at4", 32'(zero), 0);
        en = 1'b0;
        tick();
        chk("hold_at4", 32'(count), 4);

        // Count down with wrap 4 -> 15
        en = 1'b1;
        dn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("down_%0d", i), 32'(count), 32'(down_seq[i]));
            if (i == 3) begin
                chk("tc_down_at0", 32'(tc), 1);
                chk("zero_at0", 32'(zero), 1);
            end
        end
        chk("ones_at15", 32'(ones), 1);
        chk("tc_down_at15", 32'(tc), 0);

        // Reset mid-run with en high
        rst = 1'b1;
        tick();
        chk("midrst_count", 32'(count), 0);
        chk("midrst_tc", 32'(tc), 1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("postrst_%0d", i), 32'(count), 32'(rst_seq[i]));
        end

        // Direction change and up-wrap 13 -> 1
        dn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("upwrap_%0d", i), 32'(count), 32'(wrap_seq[i]));
            if (i == 1) begin
                chk("tc_up_at15", 32'(tc), 1);
                chk("ones_up_at15", 32'(ones), 1);
            end
        end
        chk("tc_up_at1", 32'(tc), 0);

        // dn toggling while disabled has no effect
        en = 1'b0;
        dn = 1'b1;
        tick();
        dn = 1'b0;
        tick();
        chk("hold_dn_toggle", 32'(count), 1);
        chk("tc_disabled", 32'(tc), 0);

`ifdef COUNTER_SATURATE_EN
        // Climb 1 -> 15, then two more up edges must stay at 15
        en = 1'b1;
        dn = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("sat_reach15", 32'(count), 15);
        chk("sat_tc15", 32'(tc), 1);
        tick();
        tick();
        chk("sat_hold15", 32'(count), 15);
        dn = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        chk("sat_reach0", 32'(count), 0);
        chk("sat_tc0", 32'(tc), 1);
        tick();
        tick();
        chk("sat_hold0", 32'(count), 0);
        en = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
